// File: rtl/instr_bus_pkg.sv
// Shared types and constants for the MR1 instruction-fetch responder.
package instr_bus_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int STALL_CNT_W = 3;

    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [DATA_W-1:0]      word_t;
    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

endpackage

// File: rtl/instr_req_fifo.sv
// In-order request queue for fetch addresses. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module instr_req_fifo
    import instr_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = instr_bus_pkg::ADDR_W,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance for this cycle's push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Pointer and storage registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/instr_bus_responder.sv
// Responder side of the MR1 instruction-fetch bus: queues fetch requests,
// returns one word per request in order, and bounds both stall inputs so
// the core always makes progress.
module instr_bus_responder
    import instr_bus_pkg::*;
#(
    parameter int ADDR_W    = instr_bus_pkg::ADDR_W,
    parameter int DATA_W    = instr_bus_pkg::DATA_W,
    parameter int DEPTH     = 2,
    parameter int MAX_STALL = 3,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_req_valid,
    output logic              instr_req_ready,
    input  logic [ADDR_W-1:0] instr_req_addr,
    output logic              instr_rsp_valid,
    output logic [DATA_W-1:0] instr_rsp_data,
    input  logic              stall_req,
    input  logic              stall_rsp,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_misaligned
);

    localparam stall_cnt_t MAX_CNT = stall_cnt_t'(MAX_STALL);

    stall_cnt_t        req_cnt_q, req_cnt_d;
    stall_cnt_t        rsp_cnt_q, rsp_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              err_q, err_d;

    logic              full;
    logic              empty;
    logic              req_stall;
    logic              rsp_stall;
    logic              accept;
    logic              issue;

    // A stall is only honoured while its counter is below the bound.
    assign req_stall       = stall_req && (req_cnt_q < MAX_CNT);
    assign rsp_stall       = stall_rsp && (rsp_cnt_q < MAX_CNT);
    assign instr_req_ready = !full && !req_stall;
    assign accept          = instr_req_valid && instr_req_ready;
    assign issue           = !empty && !rsp_stall;

    assign instr_rsp_valid = rsp_valid_q;
    assign instr_rsp_data  = rsp_data_q;
    assign err_misaligned  = err_q;

    instr_req_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (accept),
        .data_i  (instr_req_addr),
        .pop_i   (issue),
        .head_o  (mem_addr),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding)
    );

    // Next-state for stall counters, response register and sticky error.
    always_comb begin
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        rsp_valid_d = issue;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;

        // Count only cycles where the core waits purely because of stall_req.
        if (!instr_req_valid || accept) begin
            req_cnt_d = '0;
        end else if (!full && (req_cnt_q < MAX_CNT)) begin
            req_cnt_d = req_cnt_q + stall_cnt_t'(1);
        end

        if (empty || issue) begin
            rsp_cnt_d = '0;
        end else if (rsp_cnt_q < MAX_CNT) begin
            rsp_cnt_d = rsp_cnt_q + stall_cnt_t'(1);
        end

        if (issue) begin
            rsp_data_d = mem_rdata;
        end

        if (accept && (instr_req_addr[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    // Control and response registers; reset flushes everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/instr_bus_responder.md
# instr_bus_responder

Responder end of the MR1 instruction-fetch interface (`instr_req_*` / `instr_rsp_*`): accepts fetch requests from the core, queues them in order, and returns one instruction word per request. Sits opposite MR1 in formal wrappers and simulation benches. Stall inputs come from free/random sources and are bounded by `MAX_STALL`, which guarantees fetch progress for riscv-formal liveness checks. Read data comes from an external memory/lookup port so that the same block serves random-data formal runs and program-image simulation.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, instruction word width
- `DEPTH`, 2, max outstanding requests; power of two, 2..8
- `MAX_STALL`, 3, max consecutive cycles either stall input is honoured; 1..7

- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `instr_req_valid`  in  1  core presents fetch request
- `instr_req_ready`  out  1  responder accepts request this cycle
- `instr_req_addr`  in  ADDR_W  fetch address
- `instr_rsp_valid`  out  1  one-cycle response pulse; the core cannot back-pressure
- `instr_rsp_data`  out  DATA_W  instruction word, valid with `instr_rsp_valid`
- `stall_req`  in  1  request to withhold `instr_req_ready`
- `stall_rsp`  in  1  request to delay the next response
- `mem_addr`  out  ADDR_W  address of the oldest queued request (head)
- `mem_rdata`  in  DATA_W  combinational read of `mem_addr`
- `outstanding`  out  $clog2(DEPTH+1)  queue occupancy
- `err_misaligned`  out  1  sticky; set by an accepted address with `addr[1:0] != 0`

## Operation
- **Accept:** `instr_req_ready = !full && !(stall_req && req_stall_cnt < MAX_STALL)`. On `valid && ready`, push `instr_req_addr` into the queue.
- **req_stall_cnt:**
  - +1 each cycle with `valid && !ready && !full`.
  - Cleared on accept or when `!valid`.
  - Saturates at `MAX_STALL`; at that value the stall is ignored.
- **Full:** `full` blocks accept even if a pop happens the same cycle (no bypass). Full cycles do not advance `req_stall_cnt`.
- **Issue:** in any cycle with `!empty && !(stall_rsp && rsp_stall_cnt < MAX_STALL)`:
  - Register `mem_rdata` into `instr_rsp_data`.
  - Set `instr_rsp_valid` for the next cycle.
  - Pop the head.
- **rsp_stall_cnt:**
  - +1 each cycle with `!empty` and issue blocked.
  - Cleared on issue or when empty.
  - Saturates at `MAX_STALL`.
- **Ordering:** responses are strictly in request order. Exactly one response per accepted request.
- **Simultaneous push and pop:** occupancy unchanged; the pushed entry lands behind the head.
- **Pointers:** `log2(DEPTH)+1` bits and wrap modulo `DEPTH`. Full and empty are distinguished by the MSB.
- **`mem_addr` when empty:** holds the last head address. Its value is don't-care.
- **Misaligned addresses:** still serviced unchanged; `err_misaligned` only flags them.
- **Reset mid-operation:** the queue is flushed, all in-flight responses are dropped, and both counters are cleared.

## Timing
- **Reset values** (first cycle after reset asserted):
  - `instr_req_ready` = 1, combinational with empty queue and counter 0, subject to `stall_req`
  - `instr_rsp_valid` = 0, `instr_rsp_data` = 0
  - `outstanding` = 0, `err_misaligned` = 0, `mem_addr` = 0
- **Latency:** a handshake in cycle t makes the head visible in t+1, so `instr_rsp_valid` is high in t+2 at the earliest. The worst case with no queueing is t+2+`MAX_STALL`.
- **Back-to-back:** `instr_rsp_valid` may be high on consecutive cycles. A request accepted every cycle is sustained at `DEPTH` ≥ 2 with both stalls low.
- **Outputs:** `outstanding` and `err_misaligned` are registered. `instr_req_ready` is combinational from registered state and `stall_req` only, never from `instr_req_valid`.

## Structure
- Package `instr_bus_pkg`:
  - `ADDR_W` and `DATA_W` defaults
  - `addr_t` and `word_t` typedefs
  - stall-counter width constant (3 bits)
- Sub-module `instr_req_fifo`:
  - Parameterised synchronous FIFO storing `addr_t`
  - Ports: push, pop, head, full, empty, count
- Top level holds: the two stall counters, the response register, the sticky error flag.

## Test plan
- **Basic fetch:** both stalls 0, `mem_rdata = addr ^ 32'hA5A5_0000`; one request at 0x100 accepted in cycle 5 → `instr_rsp_valid` in cycle 7 only, data 0xA5A5_0100, `outstanding` 1 then 0.
- **Stream:** requests 0x0, 0x4, 0x8, 0xC on consecutive cycles, `DEPTH=2` → all accepted without a gap, four in-order pulses on consecutive cycles, `outstanding` never exceeds 2.
- **Fairness bound:** `stall_req` and `stall_rsp` held at 1, `MAX_STALL=3` → ready rises after exactly 3 stalled cycles; response arrives 3 cycles after its earliest slot.
- **Full:** `stall_rsp` held at 1, `DEPTH=2`, 3 requests → third request sees ready=0 until the first pop; no loss or duplication.
- **Misaligned:** address 0x102 → response still returned, `err_misaligned` = 1 and stays set after further aligned requests until reset.
- **Reset mid-flight:** 2 outstanding requests, reset for 1 cycle → no `instr_rsp_valid` afterwards, `outstanding` = 0; next request behaves as in the basic-fetch scenario.
